// File: rtl/vga_letter_scheduler_if.sv
// Letter producer handshake into the VGA letter scheduler.
interface vga_letter_scheduler_if;
  logic       in_valid;
  logic [7:0] in_letter;
  logic       in_ready;

  modport master (output in_valid, output in_letter, input in_ready);
  modport slave  (input in_valid, input in_letter, output in_ready);
endinterface

// File: rtl/vga_letter_scheduler.sv
// Buffers producer letters and left-scrolls them into three renderer slots on frame boundaries.
// Optional macro LETTER_FILTER_EN: store only 'A'..'Z' or BLANK_CODE, count the rest on rej_cnt.
module vga_letter_scheduler #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned FRAMES_PER_STEP = 30,
  parameter logic [7:0]  BLANK_CODE      = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst,
  vga_letter_scheduler_if.slave   in_if,
  input  logic                    clr_req,
  input  logic                    frame_start,
  output logic [7:0]              letter_sel_one,
  output logic [7:0]              letter_sel_two,
  output logic [7:0]              letter_sel_three,
  output logic [3:0]              pending,
  output logic                    busy
`ifdef LETTER_FILTER_EN
  ,
  output logic [7:0]              rej_cnt
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, CLR_PEND} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]        count_d;
  logic              full_q, full_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [7:0]        one_d, two_d, three_d;
  logic              ready_c, push_c, store_c, letter_ok_c, pop_c, flush_c;

  // Ready depends only on registered state so a full FIFO refuses even while popping.
  assign ready_c        = !rst && !full_q && (state_q != CLR_PEND);
  assign in_if.in_ready = ready_c;
  assign push_c         = in_if.in_valid && ready_c;
  assign store_c        = push_c && letter_ok_c;

`ifdef LETTER_FILTER_EN
  assign letter_ok_c = ((in_if.in_letter >= 8'h41) && (in_if.in_letter <= 8'h5A)) ||
                       (in_if.in_letter == BLANK_CODE);
`else
  assign letter_ok_c = 1'b1;
`endif

  // Next-state, step counter and slot scroll.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    pop_c    = 1'b0;
    flush_c  = 1'b0;
    one_d    = letter_sel_one;
    two_d    = letter_sel_two;
    three_d  = letter_sel_three;

    case (state_q)
      IDLE: begin
        step_d = '0;
        if (clr_req)      state_d = CLR_PEND;
        else if (store_c) state_d = WAIT;
      end
      WAIT: begin
        if (clr_req) begin
          state_d = CLR_PEND;
        end else if (frame_start) begin
          if (step_q == STEP_W'(FRAMES_PER_STEP - 1)) begin
            pop_c  = 1'b1;
            step_d = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      CLR_PEND: begin
        if (frame_start) begin
          flush_c = 1'b1;
          step_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_c) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = pending + 4'(store_c) - 4'(pop_c);
      wr_ptr_d = wr_ptr_q + PTR_W'(store_c);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    end
    full_d = (count_d == 4'(DEPTH));

    if (pop_c && (count_d == 4'd0)) state_d = IDLE;

    if (flush_c) begin
      one_d   = BLANK_CODE;
      two_d   = BLANK_CODE;
      three_d = BLANK_CODE;
    end else if (pop_c) begin
      one_d   = letter_sel_two;
      two_d   = letter_sel_three;
      three_d = mem[rd_ptr_q];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      pending          <= '0;
      full_q           <= 1'b0;
      step_q           <= '0;
      busy             <= 1'b0;
      letter_sel_one   <= BLANK_CODE;
      letter_sel_two   <= BLANK_CODE;
      letter_sel_three <= BLANK_CODE;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      pending          <= count_d;
      full_q           <= full_d;
      step_q           <= step_d;
      busy             <= (count_d != 4'd0) || (state_d == CLR_PEND);
      letter_sel_one   <= one_d;
      letter_sel_two   <= two_d;
      letter_sel_three <= three_d;
    end
  end

  // Letter storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (store_c) mem[wr_ptr_q] <= in_if.in_letter;
  end

`ifdef LETTER_FILTER_EN
  // Saturating count of consumed-but-dropped letters.
  always_ff @(posedge clk) begin
    if (rst || flush_c)                                 rej_cnt <= '0;
    else if (push_c && !letter_ok_c && rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_letter_scheduler.sv
// Directed vector bench for vga_letter_scheduler (FRAMES_PER_STEP=1 and =3 instances).
module tb_vga_letter_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr1 = 1'b0, fs1 = 1'b0, clr3 = 1'b0, fs3 = 1'b0;
  logic [7:0] one1, two1, three1, one3, two3, three3;
  logic [3:0] pend1, pend3;
  logic busy1, busy3;
`ifdef LETTER_FILTER_EN
  logic [7:0] rej1, rej3;
`endif

  int checks = 0;
  int errors = 0;

  vga_letter_scheduler_if bus1 ();
  vga_letter_scheduler_if bus3 ();

  always #5 clk = ~clk;

  vga_letter_scheduler #(.DEPTH(8), .FRAMES_PER_STEP(1), .BLANK_CODE(8'h20)) dut1 (
    .clk(clk), .rst(rst), .in_if(bus1), .clr_req(clr1), .frame_start(fs1),
    .letter_sel_one(one1), .letter_sel_two(two1), .letter_sel_three(three1),
    .pending(pend1), .busy(busy1)
`ifdef LETTER_FILTER_EN
    , .rej_cnt(rej1)
`endif
  );

  vga_letter_scheduler #(.DEPTH(8), .FRAMES_PER_STEP(3), .BLANK_CODE(8'h20)) dut3 (
    .clk(clk), .rst(rst), .in_if(bus3), .clr_req(clr3), .frame_start(fs3),
    .letter_sel_one(one3), .letter_sel_two(two3), .letter_sel_three(three3),
    .pending(pend3), .busy(busy3)
`ifdef LETTER_FILTER_EN
    , .rej_cnt(rej3)
`endif
  );

  typedef struct {
    logic        v;
    logic [7:0]  l;
    logic        c;
    logic        f;
    logic [29:0] exp;  // {ready, one, two, three, pending, busy}
  } vec_t;

  function automatic vec_t mkv(logic v, logic [7:0] l, logic c, logic f, logic r,
                               logic [7:0] a, logic [7:0] b, logic [7:0] d,
                               logic [3:0] p, logic bz);
    vec_t x;
    x.v = v; x.l = l; x.c = c; x.f = f;
    x.exp = {r, a, b, d, p, bz};
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] obs1();
    return {bus1.in_ready, one1, two1, three1, pend1, busy1};
  endfunction

  vec_t vt [19];
  logic [7:0] letters [10];
  int idx;
  logic acc;

  initial begin
    bus1.in_valid = 1'b0; bus1.in_letter = 8'h00;
    bus3.in_valid = 1'b0; bus3.in_letter = 8'h00;

    // Basic scroll, clear and clear-timing corners for FRAMES_PER_STEP=1.
    vt[0]  = mkv(1, 8'h51, 0, 0, 1, 8'h20, 8'h20, 8'h20, 4'd1, 1);
    vt[1]  = mkv(1, 8'h49, 0, 0, 1, 8'h20, 8'h20, 8'h20, 4'd2, 1);
    vt[2]  = mkv(1, 8'h41, 0, 0, 1, 8'h20, 8'h20, 8'h20, 4'd3, 1);
    vt[3]  = mkv(0, 8'h00, 0, 1, 1, 8'h20, 8'h20, 8'h51, 4'd2, 1);
    vt[4]  = mkv(0, 8'h00, 0, 1, 1, 8'h20, 8'h51, 8'h49, 4'd1, 1);
    vt[5]  = mkv(0, 8'h00, 0, 1, 1, 8'h51, 8'h49, 8'h41, 4'd0, 0);
    vt[6]  = mkv(0, 8'h00, 0, 0, 1, 8'h51, 8'h49, 8'h41, 4'd0, 0);
    vt[7]  = mkv(1, 8'h4B, 0, 0, 1, 8'h51, 8'h49, 8'h41, 4'd1, 1);
    vt[8]  = mkv(1, 8'h4C, 0, 0, 1, 8'h51, 8'h49, 8'h41, 4'd2, 1);
    vt[9]  = mkv(0, 8'h00, 1, 0, 0, 8'h51, 8'h49, 8'h41, 4'd2, 1);
    vt[10] = mkv(1, 8'h4D, 0, 0, 0, 8'h51, 8'h49, 8'h41, 4'd2, 1);
    vt[11] = mkv(0, 8'h00, 1, 0, 0, 8'h51, 8'h49, 8'h41, 4'd2, 1);
    vt[12] = mkv(0, 8'h00, 0, 1, 1, 8'h20, 8'h20, 8'h20, 4'd0, 0);
    vt[13] = mkv(0, 8'h00, 0, 1, 1, 8'h20, 8'h20, 8'h20, 4'd0, 0);
    vt[14] = mkv(1, 8'h4E, 1, 0, 0, 8'h20, 8'h20, 8'h20, 4'd1, 1);
    vt[15] = mkv(0, 8'h00, 0, 1, 1, 8'h20, 8'h20, 8'h20, 4'd0, 0);
    vt[16] = mkv(0, 8'h00, 1, 1, 0, 8'h20, 8'h20, 8'h20, 4'd0, 1);
    vt[17] = mkv(0, 8'h00, 0, 0, 0, 8'h20, 8'h20, 8'h20, 4'd0, 1);
    vt[18] = mkv(0, 8'h00, 0, 1, 1, 8'h20, 8'h20, 8'h20, 4'd0, 0);
    for (int i = 0; i < 10; i++) letters[i] = 8'(8'h41 + i);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(obs1()), 32'({1'b0, 8'h20, 8'h20, 8'h20, 4'd0, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus1.in_ready), 32'd1);

    // FRAMES_PER_STEP=3: commit only on the third frame_start.
    @(negedge clk); bus3.in_valid = 1'b1; bus3.in_letter = 8'h51;
    @(posedge clk); #1; bus3.in_valid = 1'b0;
    chk("fps3_pending", 32'(pend3), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); fs3 = 1'b1;
      @(posedge clk); #1; fs3 = 1'b0;
      chk($sformatf("fps3_frame%0d", k), 32'({one3, two3, three3, pend3}),
          (k < 3) ? 32'({8'h20, 8'h20, 8'h20, 4'd1}) : 32'({8'h20, 8'h20, 8'h51, 4'd0}));
      @(negedge clk);
    end
    chk("fps3_busy_end", 32'(busy3), 32'd0);

    // Vector table.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus1.in_valid = vt[i].v; bus1.in_letter = vt[i].l; clr1 = vt[i].c; fs1 = vt[i].f;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 32'(obs1()), 32'(vt[i].exp));
    end
    @(negedge clk);
    bus1.in_valid = 1'b0; clr1 = 1'b0; fs1 = 1'b0;

    // Fill: hold in_valid with DEPTH+2 letters, no frame_start.
    idx = 0;
    for (int n = 0; n < 12 && idx < 10; n++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1; bus1.in_letter = letters[idx];
      #1; acc = bus1.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("fill_accepted", 32'(idx), 32'd8);
    chk("fill_ready", 32'(bus1.in_ready), 32'd0);
    chk("fill_pending", 32'(pend1), 32'd8);

    // Full FIFO: frame_start + push in the same cycle refuses the push.
    @(negedge clk);
    fs1 = 1'b1; bus1.in_valid = 1'b1; bus1.in_letter = letters[8];
    #1;
    chk("full_pop_ready", 32'(bus1.in_ready), 32'd0);
    @(posedge clk); #1;
    fs1 = 1'b0;
    chk("full_pop_pending", 32'(pend1), 32'd7);
    chk("full_pop_slots", 32'({one1, two1, three1}), 32'({8'h20, 8'h20, 8'h41}));
    chk("full_pop_ready_after", 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    chk("full_retry_pending", 32'(pend1), 32'd8);

    // Mid-operation reset.
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_state", 32'(obs1()), 32'({1'b0, 8'h20, 8'h20, 8'h20, 4'd0, 1'b0}));
    @(negedge clk); rst = 1'b0;

    // Letter filter: '3', 'Z', 8'h7F.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.in_letter = (k == 0) ? 8'h33 : (k == 1) ? 8'h5A : 8'h7F;
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b0;
`ifdef LETTER_FILTER_EN
    chk("filter_pending", 32'(pend1), 32'd1);
    chk("filter_rej_cnt", 32'(rej1), 32'd2);
`else
    chk("nofilter_pending", 32'(pend1), 32'd3);
`endif
    @(negedge clk); fs1 = 1'b1;
    @(posedge clk); #1; fs1 = 1'b0;
`ifdef LETTER_FILTER_EN
    chk("filter_commit", 32'(three1), 32'h5A);
`else
    chk("nofilter_commit", 32'(three1), 32'h33);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
